// File: rtl/lpddr5_ca_decoder_if.sv
// Decoded-command stream between the LPDDR5 CA decoder and its consumer.
interface lpddr5_ca_decoder_if;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned PAY_W  = 14;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [CODE_W-1:0] cmd_code;
  logic [PAY_W-1:0]  cmd_payload;

  modport master (output cmd_valid, output cmd_code, output cmd_payload, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, input cmd_payload, output cmd_ready);
endinterface

// File: rtl/lpddr5_ca_decoder.sv
// LPDDR5 CA bus decoder: samples cs/ca each ck_t edge, decodes one- and
// two-cycle commands, queues them in a small FIFO and flags protocol errors.
// Optional refresh watchdog enabled by defining LPDDR5_REF_WATCHDOG_EN.
module lpddr5_ca_decoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TREFI_MAX  = 1024
) (
  input  logic                ck_t,
  input  logic                ddr_reset_n,
  input  logic                cs,
  input  logic [6:0]          ca,
  lpddr5_ca_decoder_if.master cmd_if,
  output logic                err_illegal,
  output logic                err_seq,
  output logic                err_ovf,
  output logic                ref_late
);
  localparam int unsigned CA_W   = 7;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned PAY_W  = 2 * CA_W;
  localparam int unsigned ENT_W  = CODE_W + PAY_W;
  localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = AW + 1;

  localparam logic [CODE_W-1:0] C_ACT  = 5'd1;
  localparam logic [CODE_W-1:0] C_PRE  = 5'd2;
  localparam logic [CODE_W-1:0] C_REF  = 5'd3;
  localparam logic [CODE_W-1:0] C_MWR  = 5'd4;
  localparam logic [CODE_W-1:0] C_WR16 = 5'd5;
  localparam logic [CODE_W-1:0] C_WR32 = 5'd6;
  localparam logic [CODE_W-1:0] C_RD16 = 5'd7;
  localparam logic [CODE_W-1:0] C_RD32 = 5'd8;
  localparam logic [CODE_W-1:0] C_CAS  = 5'd9;
  localparam logic [CODE_W-1:0] C_MPC  = 5'd10;
  localparam logic [CODE_W-1:0] C_SRE  = 5'd11;
  localparam logic [CODE_W-1:0] C_MRW  = 5'd12;
  localparam logic [CODE_W-1:0] C_MRR  = 5'd13;
  localparam logic [CODE_W-1:0] C_WFF  = 5'd14;
  localparam logic [CODE_W-1:0] C_RFF  = 5'd15;
  localparam logic [CODE_W-1:0] C_PDE  = 5'd16;
  localparam logic [CODE_W-1:0] C_PDX  = 5'd17;

  typedef enum logic [1:0] {S_IDLE, S_SECOND, S_PD} state_t;
  typedef enum logic [1:0] {K_NOP, K_ONE, K_TWO, K_BAD} kind_t;

  state_t              state_q, state_d;
  logic [CA_W-1:0]     first_q, first_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_illegal_q, err_illegal_d;
  logic                err_seq_q, err_seq_d;
  logic                err_ovf_q, err_ovf_d;
  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];

  kind_t               dec_kind;
  logic [CODE_W-1:0]   dec_code;
  logic                second_ok;
  logic                push, pop, full, wr_en;
  logic [CODE_W-1:0]   push_code;
  logic [PAY_W-1:0]    push_pay;
  logic [ENT_W-1:0]    head;

  // First-sample pattern decode (ca[6] is CA0, so literals read CA0..CA6)
  always_comb begin
    dec_kind = K_BAD;
    dec_code = '0;
    casez (ca)
      7'b0000000: dec_kind = K_NOP;
      7'b111????: begin dec_kind = K_TWO; dec_code = C_ACT;  end
      7'b0001101: begin dec_kind = K_TWO; dec_code = C_MRW;  end
      7'b0001111: begin dec_kind = K_ONE; dec_code = C_PRE;  end
      7'b0001110: begin dec_kind = K_ONE; dec_code = C_REF;  end
      7'b010????: begin dec_kind = K_ONE; dec_code = C_MWR;  end
      7'b011????: begin dec_kind = K_ONE; dec_code = C_WR16; end
      7'b0010???: begin dec_kind = K_ONE; dec_code = C_WR32; end
      7'b100????: begin dec_kind = K_ONE; dec_code = C_RD16; end
      7'b101????: begin dec_kind = K_ONE; dec_code = C_RD32; end
      7'b0011???: begin dec_kind = K_ONE; dec_code = C_CAS;  end
      7'b000011?: begin dec_kind = K_ONE; dec_code = C_MPC;  end
      7'b0001011: begin dec_kind = K_ONE; dec_code = C_SRE;  end
      7'b0001100: begin dec_kind = K_ONE; dec_code = C_MRR;  end
      7'b0000011: begin dec_kind = K_ONE; dec_code = C_WFF;  end
      7'b0000010: begin dec_kind = K_ONE; dec_code = C_RFF;  end
      7'b0000001: begin dec_kind = K_ONE; dec_code = C_PDE;  end
      default:    dec_kind = K_BAD;
    endcase
  end

  // ACT and MRW are told apart by CA0 of the latched first half
  assign second_ok = first_q[6] ? (ca[6:4] == 3'b110) : (ca[6:1] == 6'b000100);

  // Command FSM: next state, push request and error pulses
  always_comb begin
    state_d       = state_q;
    first_d       = first_q;
    push          = 1'b0;
    push_code     = '0;
    push_pay      = '0;
    err_illegal_d = 1'b0;
    err_seq_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cs) begin
          case (dec_kind)
            K_NOP: ;
            K_TWO: begin
              state_d = S_SECOND;
              first_d = ca;
            end
            K_ONE: begin
              push      = 1'b1;
              push_code = dec_code;
              push_pay  = {ca, CA_W'(0)};
              if (dec_code == C_PDE) state_d = S_PD;
            end
            default: err_illegal_d = 1'b1;
          endcase
        end
      end
      S_SECOND: begin
        state_d = S_IDLE;
        if (cs && second_ok) begin
          push      = 1'b1;
          push_code = first_q[6] ? C_ACT : C_MRW;
          push_pay  = {first_q, ca};
        end else begin
          err_seq_d = 1'b1;
        end
      end
      S_PD: begin
        if (cs) begin
          err_illegal_d = 1'b1;
        end else if (ca == 7'b0000001) begin
          push      = 1'b1;
          push_code = C_PDX;
          push_pay  = {7'b0000001, CA_W'(0)};
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping; a pop frees the slot a same-cycle push fills
  always_comb begin
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    pop       = (count_q != '0) && cmd_if.cmd_ready;
    wr_en     = push && (!full || pop);
    count_d   = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    wr_ptr_d  = wr_ptr_q + AW'(wr_en);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    err_ovf_d = err_ovf_q | (push && full && !pop);
  end

  // State and control registers
  always_ff @(posedge ck_t) begin
    if (!ddr_reset_n) begin
      state_q       <= S_IDLE;
      first_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      err_illegal_q <= 1'b0;
      err_seq_q     <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      first_q       <= first_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      err_illegal_q <= err_illegal_d;
      err_seq_q     <= err_seq_d;
      err_ovf_q     <= err_ovf_d;
    end
  end

  // FIFO storage
  always_ff @(posedge ck_t) begin
    if (ddr_reset_n && wr_en) mem_q[wr_ptr_q] <= {push_code, push_pay};
  end

  assign head               = mem_q[rd_ptr_q];
  assign cmd_if.cmd_valid   = (count_q != '0);
  assign cmd_if.cmd_code    = cmd_if.cmd_valid ? head[ENT_W-1:PAY_W] : '0;
  assign cmd_if.cmd_payload = cmd_if.cmd_valid ? head[PAY_W-1:0] : '0;
  assign err_illegal        = err_illegal_q;
  assign err_seq            = err_seq_q;
  assign err_ovf            = err_ovf_q;

`ifdef LPDDR5_REF_WATCHDOG_EN
  localparam int unsigned REF_W = 16;

  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  logic             ref_late_q, ref_late_d;
  logic             ref_seen;

  assign ref_seen = (state_q == S_IDLE) && cs && (ca == 7'b0001110);

  // Refresh interval counter: frozen in power-down, saturating, one pulse per interval
  always_comb begin
    ref_cnt_d  = ref_cnt_q;
    ref_late_d = 1'b0;
    if (ref_seen) begin
      ref_cnt_d = '0;
    end else if (state_q != S_PD && ref_cnt_q != {REF_W{1'b1}}) begin
      ref_cnt_d  = ref_cnt_q + REF_W'(1);
      ref_late_d = (ref_cnt_d == REF_W'(TREFI_MAX));
    end
  end

  // Watchdog registers
  always_ff @(posedge ck_t) begin
    if (!ddr_reset_n) begin
      ref_cnt_q  <= '0;
      ref_late_q <= 1'b0;
    end else begin
      ref_cnt_q  <= ref_cnt_d;
      ref_late_q <= ref_late_d;
    end
  end

  assign ref_late = ref_late_q;
`else
  assign ref_late = 1'b0;
`endif

endmodule

// File: tb/tb_lpddr5_ca_decoder.sv
// Bench for lpddr5_ca_decoder: directed scenarios plus a random stream
// checked against a pattern-table model of the CA protocol.
module tb_lpddr5_ca_decoder;
`ifdef LPDDR5_REF_WATCHDOG_EN
  localparam int TREFI = 8;
  localparam bit WDOG  = 1'b1;
`else
  localparam int TREFI = 1024;
  localparam bit WDOG  = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic       ck_t, ddr_reset_n, cs;
  logic [6:0] ca;
  logic       err_illegal, err_seq, err_ovf, ref_late;

  lpddr5_ca_decoder_if bus();

  lpddr5_ca_decoder #(.FIFO_DEPTH(DEPTH), .TREFI_MAX(TREFI)) dut (
    .ck_t        (ck_t),
    .ddr_reset_n (ddr_reset_n),
    .cs          (cs),
    .ca          (ca),
    .cmd_if      (bus),
    .err_illegal (err_illegal),
    .err_seq     (err_seq),
    .err_ovf     (err_ovf),
    .ref_late    (ref_late)
  );

  initial begin
    ck_t = 1'b0;
    forever #5 ck_t = ~ck_t;
  end

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_state;       // 0 idle, 1 awaiting second half, 2 power-down
  logic [6:0]  m_first;
  int          m_first_code;
  logic [18:0] m_q [$];
  bit          m_ovf, e_ill, e_seq, e_late;
  int          m_refcnt;

  string first_pat [16] = '{"111xxxx", "0001101", "0001111", "0001110",
                            "010xxxx", "011xxxx", "0010xxx", "100xxxx",
                            "101xxxx", "0011xxx", "000011x", "0001011",
                            "0001100", "0000011", "0000010", "0000001"};
  int first_code [16] = '{1, 12, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 13, 14, 15, 16};
  int first_len  [16] = '{2, 2, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  logic [6:0] picks [8] = '{7'b1110101, 7'b1100011, 7'b0001101, 7'b0001000,
                            7'b0001110, 7'b0000000, 7'b0000001, 7'b0001111};

  function automatic bit match(input string p, input logic [6:0] a);
    for (int k = 0; k < 7; k++) begin
      if (p[k] != "x") begin
        if ((p[k] == "1") != (a[6-k] == 1'b1)) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic void lookup(input logic [6:0] a, output int code, output int len);
    code = -1;
    len  = 0;
    for (int i = 0; i < 16; i++) begin
      if (match(first_pat[i], a)) begin
        code = first_code[i];
        len  = first_len[i];
      end
    end
  endfunction

  // Drive one CA sample, advance the model, then step past the edge
  task automatic cycle(input logic c, input logic [6:0] a, input logic r);
    int          code, len, st0;
    bit          push, is_ref;
    logic [18:0] ent, dropped;
    string       sp;
    cs = c; ca = a; bus.cmd_ready = r;
    e_ill = 0; e_seq = 0; e_late = 0; push = 0; is_ref = 0; ent = '0;
    st0 = m_state;
    case (m_state)
      0: if (c && a != 7'd0) begin
        lookup(a, code, len);
        if (code < 0) e_ill = 1;
        else if (len == 2) begin
          m_state = 1; m_first = a; m_first_code = code;
        end else begin
          push = 1; ent = {5'(code), a, 7'd0};
          is_ref = (code == 3);
          if (code == 16) m_state = 2;
        end
      end
      1: begin
        m_state = 0;
        if (m_first_code == 1) sp = "110xxxx";
        else sp = "000100x";
        if (c && match(sp, a)) begin
          push = 1; ent = {5'(m_first_code), m_first, a};
        end else e_seq = 1;
      end
      default: begin
        if (c) e_ill = 1;
        else if (a == 7'b0000001) begin
          push = 1; ent = {5'd17, 7'b0000001, 7'd0}; m_state = 0;
        end
      end
    endcase
    if (r && m_q.size() > 0) dropped = m_q.pop_front();
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(ent);
      else m_ovf = 1;
    end
    if (WDOG) begin
      if (is_ref) m_refcnt = 0;
      else if (st0 != 2 && m_refcnt < 65535) begin
        m_refcnt++;
        if (m_refcnt == TREFI) e_late = 1;
      end
    end
    @(posedge ck_t); #1;
  endtask

  task automatic do_reset();
    ddr_reset_n = 1'b0; cs = 1'b0; ca = '0; bus.cmd_ready = 1'b0;
    @(posedge ck_t); #1;
    ddr_reset_n = 1'b1;
    m_state = 0; m_q.delete(); m_ovf = 0; e_ill = 0; e_seq = 0; e_late = 0; m_refcnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.cmd_valid); end
    if (bus.cmd_code !== 5'd0) begin errors++; $display("FAIL reset_code got=%0d exp=0", bus.cmd_code); end
    if (bus.cmd_payload !== 14'd0) begin errors++; $display("FAIL reset_payload got=%h exp=0", bus.cmd_payload); end
    if (err_illegal !== 1'b0) begin errors++; $display("FAIL reset_err_illegal got=%b exp=0", err_illegal); end
    if (err_seq !== 1'b0) begin errors++; $display("FAIL reset_err_seq got=%b exp=0", err_seq); end
    if (err_ovf !== 1'b0) begin errors++; $display("FAIL reset_err_ovf got=%b exp=0", err_ovf); end
    if (ref_late !== 1'b0) begin errors++; $display("FAIL reset_ref_late got=%b exp=0", ref_late); end
  endtask

  task automatic test_act();
    do_reset();
    cycle(1'b1, 7'b1110101, 1'b1);
    checks++;
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL act_half_valid got=%b exp=0", bus.cmd_valid); end
    cycle(1'b1, 7'b1100011, 1'b1);
    checks += 3;
    if (bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL act_valid got=%b exp=1", bus.cmd_valid); end
    if (bus.cmd_code !== 5'd1) begin errors++; $display("FAIL act_code got=%0d exp=1", bus.cmd_code); end
    if (bus.cmd_payload !== {7'b1110101, 7'b1100011}) begin
      errors++; $display("FAIL act_payload got=%b exp=%b", bus.cmd_payload, {7'b1110101, 7'b1100011});
    end
    cycle(1'b0, 7'd0, 1'b1);
    checks++;
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL act_single got=%b exp=0", bus.cmd_valid); end
  endtask

  task automatic test_bad_second();
    do_reset();
    cycle(1'b1, 7'b0001101, 1'b1);
    cycle(1'b1, 7'b0111111, 1'b1);
    checks += 2;
    if (err_seq !== 1'b1) begin errors++; $display("FAIL seq_pulse got=%b exp=1", err_seq); end
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL seq_nopush got=%b exp=0", bus.cmd_valid); end
    cycle(1'b1, 7'b0001111, 1'b1);
    checks += 3;
    if (err_seq !== 1'b0) begin errors++; $display("FAIL seq_once got=%b exp=0", err_seq); end
    if (bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL seq_idle_valid got=%b exp=1", bus.cmd_valid); end
    if (bus.cmd_code !== 5'd2) begin errors++; $display("FAIL seq_idle_code got=%0d exp=2", bus.cmd_code); end
    cycle(1'b0, 7'd0, 1'b1);
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 7'b0001110, 1'b0);
      checks++;
      if (err_ovf !== (i == 4)) begin errors++; $display("FAIL ovf_flag i=%0d got=%b exp=%b", i, err_ovf, (i == 4)); end
    end
    cycle(1'b0, 7'd0, 1'b0);
    cycle(1'b0, 7'd0, 1'b0);
    checks++;
    if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", err_ovf); end
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.cmd_valid === 1'b1 && bus.cmd_code === 5'd3 && bus.cmd_payload === {7'b0001110, 7'd0}) n++;
      cycle(1'b0, 7'd0, 1'b1);
    end
    checks += 3;
    if (n != 4) begin errors++; $display("FAIL ovf_entries got=%0d exp=4", n); end
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b exp=0", bus.cmd_valid); end
    if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky_after got=%b exp=1", err_ovf); end
    do_reset();
    checks++;
    if (err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_reset got=%b exp=0", err_ovf); end
  endtask

  task automatic test_full_push_pop();
    int exp_codes [4] = '{3, 3, 3, 2};
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 7'b0001110, 1'b0);
    cycle(1'b1, 7'b0001111, 1'b1);
    checks++;
    if (err_ovf !== 1'b0) begin errors++; $display("FAIL fullpp_ovf got=%b exp=0", err_ovf); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 5'(exp_codes[i])) begin
        errors++; $display("FAIL fullpp_head i=%0d got=%b/%0d exp=1/%0d", i, bus.cmd_valid, bus.cmd_code, exp_codes[i]);
      end
      cycle(1'b0, 7'd0, 1'b1);
    end
    checks++;
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL fullpp_empty got=%b exp=0", bus.cmd_valid); end
  endtask

  task automatic test_power_down();
    do_reset();
    cycle(1'b1, 7'b0000001, 1'b1);
    checks += 2;
    if (bus.cmd_code !== 5'd16) begin errors++; $display("FAIL pd_pde_code got=%0d exp=16", bus.cmd_code); end
    if (bus.cmd_payload !== {7'b0000001, 7'd0}) begin errors++; $display("FAIL pd_pde_payload got=%b", bus.cmd_payload); end
    cycle(1'b1, 7'b0001111, 1'b1);
    checks += 2;
    if (err_illegal !== 1'b1) begin errors++; $display("FAIL pd_illegal got=%b exp=1", err_illegal); end
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL pd_no_pre got=%b exp=0", bus.cmd_valid); end
    cycle(1'b0, 7'b0011000, 1'b1);
    checks += 2;
    if (err_illegal !== 1'b0) begin errors++; $display("FAIL pd_ignore_err got=%b exp=0", err_illegal); end
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL pd_ignore_push got=%b exp=0", bus.cmd_valid); end
    cycle(1'b0, 7'b0000001, 1'b1);
    checks += 3;
    if (bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL pdx_valid got=%b exp=1", bus.cmd_valid); end
    if (bus.cmd_code !== 5'd17) begin errors++; $display("FAIL pdx_code got=%0d exp=17", bus.cmd_code); end
    if (bus.cmd_payload !== {7'b0000001, 7'd0}) begin errors++; $display("FAIL pdx_payload got=%b", bus.cmd_payload); end
    cycle(1'b0, 7'd0, 1'b1);
  endtask

  task automatic test_reset_mid_cmd();
    do_reset();
    cycle(1'b1, 7'b1110101, 1'b1);
    do_reset();
    checks += 4;
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", bus.cmd_valid); end
    if (err_illegal !== 1'b0 || err_seq !== 1'b0) begin errors++; $display("FAIL midrst_errs got=%b%b exp=00", err_illegal, err_seq); end
    if (err_ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf got=%b exp=0", err_ovf); end
    if (bus.cmd_code !== 5'd0 || bus.cmd_payload !== 14'd0) begin errors++; $display("FAIL midrst_head got=%0d/%h exp=0/0", bus.cmd_code, bus.cmd_payload); end
    cycle(1'b1, 7'b1100000, 1'b1);
    checks += 3;
    if (err_illegal !== 1'b1) begin errors++; $display("FAIL midrst_illegal got=%b exp=1", err_illegal); end
    if (err_seq !== 1'b0) begin errors++; $display("FAIL midrst_seq got=%b exp=0", err_seq); end
    if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL midrst_push got=%b exp=0", bus.cmd_valid); end
  endtask

  task automatic test_watchdog();
    bit exp;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      cycle(1'b1, 7'b0001110, 1'b1);
      for (int k = 1; k <= 20; k++) begin
        cycle(1'b1, 7'd0, 1'b1);
        exp = WDOG && (k == TREFI);
        checks++;
        if (ref_late !== exp) begin errors++; $display("FAIL ref_late pass=%0d k=%0d got=%b exp=%b", pass, k, ref_late, exp); end
      end
    end
  endtask

  task automatic test_random();
    logic       c, r;
    logic [6:0] a;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0: a = 7'($urandom);
        1: a = picks[$urandom_range(0, 7)];
        default: a = c ? 7'($urandom) : 7'b0000001;
      endcase
      cycle(c, a, r);
      checks += 5;
      if (err_illegal !== e_ill) begin errors++; $display("FAIL rnd_illegal i=%0d got=%b exp=%b", i, err_illegal, e_ill); end
      if (err_seq !== e_seq) begin errors++; $display("FAIL rnd_seq i=%0d got=%b exp=%b", i, err_seq, e_seq); end
      if (err_ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf i=%0d got=%b exp=%b", i, err_ovf, m_ovf); end
      if (ref_late !== e_late) begin errors++; $display("FAIL rnd_ref_late i=%0d got=%b exp=%b", i, ref_late, e_late); end
      if (bus.cmd_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, bus.cmd_valid, (m_q.size() > 0)); end
      if (m_q.size() > 0) begin
        checks++;
        if ({bus.cmd_code, bus.cmd_payload} !== m_q[0]) begin
          errors++; $display("FAIL rnd_head i=%0d got=%h exp=%h", i, {bus.cmd_code, bus.cmd_payload}, m_q[0]);
        end
      end
    end
  endtask

  initial begin
    ddr_reset_n = 1'b0; cs = 1'b0; ca = '0; bus.cmd_ready = 1'b0;
    test_reset();
    test_act();
    test_bad_second();
    test_overflow();
    test_full_push_pop();
    test_power_down();
    test_reset_mid_cmd();
    test_watchdog();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
